// File: rtl/pet_state_fsm.sv
// Pet mood/health state machine: ranks the four need levels, gates the feeding/medicine modes
// and owns the test-button display walk. Define PET_DEATH_EN to enable the critical counter and MUERTO.
module pet_state_fsm #(
    parameter int CRIT_LIMIT = 10,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic       test_pulse,
    input  logic [1:0] nivel_animo,
    input  logic [1:0] nivel_energia,
    input  logic [1:0] nivel_descanso,
    input  logic [1:0] nivel_medicina,
    output logic [2:0] estado,
    output logic       activo_comida,
    output logic       activo_medicina,
    output logic       muerto,
    output logic       modo_test,
    output logic       cambio_estado
);

    localparam logic [2:0] S_NEUTRAL    = 3'd0;
    localparam logic [2:0] S_FELIZ      = 3'd1;
    localparam logic [2:0] S_TRISTE     = 3'd2;
    localparam logic [2:0] S_CANSADO    = 3'd3;
    localparam logic [2:0] S_HAMBRIENTO = 3'd4;
    localparam logic [2:0] S_ENFERMO    = 3'd5;
    localparam logic [2:0] S_MUERTO     = 3'd6;

    logic [2:0] estado_r, estado_nxt_s;
    logic [2:0] idx_r, idx_nxt_s;
    logic       modo_r, modo_nxt_s;
    logic       muerto_r, muerto_nxt_s;
    logic       comida_r, comida_nxt_s;
    logic       med_r, med_nxt_s;
    logic       cambio_r, cambio_nxt_s;
    logic [2:0] eval_s;
    logic       any_zero_s;

    // Mood ranking from the current levels; the first matching need wins.
    always_comb begin
        any_zero_s = (nivel_animo == 2'd0) || (nivel_energia == 2'd0) ||
                     (nivel_descanso == 2'd0) || (nivel_medicina == 2'd0);
        if (nivel_medicina == 2'd0) begin
            eval_s = S_ENFERMO;
        end else if (nivel_energia == 2'd0) begin
            eval_s = S_HAMBRIENTO;
        end else if (nivel_descanso == 2'd0) begin
            eval_s = S_CANSADO;
        end else if (nivel_animo == 2'd0) begin
            eval_s = S_TRISTE;
        end else if (nivel_animo[1] && nivel_energia[1] && nivel_descanso[1] && nivel_medicina[1]) begin
            eval_s = S_FELIZ;
        end else begin
            eval_s = S_NEUTRAL;
        end
    end

`ifdef PET_DEATH_EN
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CRIT_LIMIT);

    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             death_s;

    // Critical counter: frozen while dead, dying, in test or on a test pulse (the tick is dropped).
    always_comb begin
        death_s      = !muerto_r && (cnt_r == LIMIT);
        muerto_nxt_s = muerto_r || death_s;
        if (muerto_r || death_s || modo_r || test_pulse) begin
            cnt_nxt_s = cnt_r;
        end else if (!any_zero_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (tick_1s && (cnt_r != LIMIT)) begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Critical counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`else
    logic unused_s;

    // Without the death feature the pet can never die and the tick is irrelevant.
    always_comb begin
        muerto_nxt_s = 1'b0;
        unused_s     = tick_1s ^ (CRIT_LIMIT > CNT_W);
    end
`endif

    // State register for the walk, the sticky death flag and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_r <= S_NEUTRAL;
            idx_r    <= 3'd0;
            modo_r   <= 1'b0;
            muerto_r <= 1'b0;
            comida_r <= 1'b0;
            med_r    <= 1'b0;
            cambio_r <= 1'b0;
        end else begin
            estado_r <= estado_nxt_s;
            idx_r    <= idx_nxt_s;
            modo_r   <= modo_nxt_s;
            muerto_r <= muerto_nxt_s;
            comida_r <= comida_nxt_s;
            med_r    <= med_nxt_s;
            cambio_r <= cambio_nxt_s;
        end
    end

    // Next state: a test pulse always takes precedence over normal evaluation.
    always_comb begin
        modo_nxt_s   = modo_r;
        idx_nxt_s    = idx_r;
        estado_nxt_s = estado_r;
        if (test_pulse) begin
            if (!modo_r) begin
                modo_nxt_s   = 1'b1;
                idx_nxt_s    = 3'd0;
                estado_nxt_s = S_NEUTRAL;
            end else if (idx_r == 3'd6) begin
                modo_nxt_s   = 1'b0;
                idx_nxt_s    = 3'd0;
                estado_nxt_s = muerto_nxt_s ? S_MUERTO : eval_s;
            end else begin
                idx_nxt_s    = idx_r + 3'd1;
                estado_nxt_s = idx_r + 3'd1;
            end
        end else if (modo_r) begin
            estado_nxt_s = estado_r;
        end else begin
            estado_nxt_s = muerto_nxt_s ? S_MUERTO : eval_s;
        end
    end

    // Output decode: enables follow the state being entered, the change flag compares codes.
    always_comb begin
        comida_nxt_s = (nivel_energia != 2'd3) && !muerto_nxt_s && !modo_nxt_s;
        med_nxt_s    = (nivel_medicina != 2'd3) && !muerto_nxt_s && !modo_nxt_s;
        cambio_nxt_s = (estado_nxt_s != estado_r);
    end

    assign estado          = estado_r;
    assign activo_comida   = comida_r;
    assign activo_medicina = med_r;
    assign muerto          = muerto_r;
    assign modo_test       = modo_r;
    assign cambio_estado   = cambio_r;

endmodule
